display_scan_ctrl: RTL and testbench

- Scan scheduler for the clock's 4-digit multiplexed 7-segment display.
- Runs an 8-slot scan frame in which even slots blank the display (ghost suppression) and odd slots drive one digit.
- Splits two 6-bit time fields into BCD digits, drives digit enables and segments, and blinks a selected field for set mode.
- Sits between the timekeeping core (supplies data_show) and the display pads.

---
 rtl/display_pkg.sv | 45 ++++
 rtl/seg7_decode.sv | 16 +
 rtl/display_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scan path.
// Segment codes are active-high, bit0 = a ... bit6 = g.
package display_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [2:0] SLOT_LO_ONES = 3'd1;
  localparam logic [2:0] SLOT_LO_TENS = 3'd3;
  localparam logic [2:0] SLOT_HI_ONES = 3'd5;
  localparam logic [2:0] SLOT_HI_TENS = 3'd7;
  localparam logic [2:0] SLOT_LAST    = 3'd7;

  localparam logic [3:0] DIG_NONE    = 4'b0000;
  localparam logic [3:0] DIG_LO_ONES = 4'b0001;
  localparam logic [3:0] DIG_LO_TENS = 4'b0010;
  localparam logic [3:0] DIG_HI_ONES = 4'b0100;
  localparam logic [3:0] DIG_HI_TENS = 4'b1000;

  // Frame-stable copy of the inputs; mask bit0 = low field, bit1 = high field.
  typedef struct packed {
    logic [1:0] mask;
    logic [5:0] hi;
    logic [5:0] lo;
  } snap_t;

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] r;
    r = v % 6'd10;
    return r[3:0];
  endfunction

  // 60..63 give a tens digit of 6 and are shown literally.
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] r;
    r = v / 6'd10;
    return r[3:0];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high 7-segment code; non-decimal codes blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = '0;
    for (int d = 0; d < 10; d++) begin
      if (i_digit == 4'(d)) o_seg = SEG_DIGIT[d];
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-slot scan scheduler for a 4-digit multiplexed 7-segment display.
// Even slots blank the pads, odd slots drive one digit of a frame-latched snapshot.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] data_show,
  input  logic [1:0]  blink_mask,
  output logic [2:0]  byte_status,
  output logic [3:0]  bytee,
  output logic [6:0]  segment,
  output logic        frame_start
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int BL_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

  logic [PS_W-1:0] r_psc;
  logic [2:0]      r_slot;
  snap_t           r_snap;
  logic [BL_W-1:0] r_blink_cnt;
  logic            r_blink_vis;
  logic [3:0]      r_bytee;
  logic [6:0]      r_segment;
  logic            r_frame_start;

  logic       w_slot_end;
  logic       w_wrap;
  logic [2:0] w_slot_nxt;
  logic [3:0] w_en;
  logic [3:0] w_digit;
  logic       w_blank;
  logic       w_show;
  logic [6:0] w_seg;

  assign w_slot_end = enable && (r_psc == PS_LAST);
  assign w_wrap     = w_slot_end && (r_slot == SLOT_LAST);
  assign w_slot_nxt = w_slot_end ? r_slot + 3'd1 : r_slot;

  // Outputs are computed from the slot being entered so that slot, enables
  // and segments all land on the same edge.
  always_comb begin
    w_en    = DIG_NONE;
    w_digit = 4'd0;
    w_blank = 1'b0;
    case (w_slot_nxt)
      SLOT_LO_ONES: begin
        w_en    = DIG_LO_ONES;
        w_digit = bcd_ones(r_snap.lo);
        w_blank = !r_blink_vis && r_snap.mask[0];
      end
      SLOT_LO_TENS: begin
        w_en    = DIG_LO_TENS;
        w_digit = bcd_tens(r_snap.lo);
        w_blank = !r_blink_vis && r_snap.mask[0];
      end
      SLOT_HI_ONES: begin
        w_en    = DIG_HI_ONES;
        w_digit = bcd_ones(r_snap.hi);
        w_blank = !r_blink_vis && r_snap.mask[1];
      end
      SLOT_HI_TENS: begin
        w_en    = DIG_HI_TENS;
        w_digit = bcd_tens(r_snap.hi);
        w_blank = !r_blink_vis && r_snap.mask[1];
      end
      default: ;
    endcase
  end

  assign w_show = (w_en != DIG_NONE) && !w_blank;

  seg7_decode u_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_psc  <= '0;
      r_slot <= '0;
    end else if (enable) begin
      r_psc  <= w_slot_end ? '0 : r_psc + 1'b1;
      r_slot <= w_slot_nxt;
    end
  end

  // Snapshot and blink state only move on the frame wrap, so a frame never tears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap      <= '0;
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (w_wrap) begin
      r_snap <= '{mask: blink_mask, hi: data_show[11:6], lo: data_show[5:0]};
      if (r_blink_cnt == BL_LAST) begin
        r_blink_cnt <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bytee       <= '0;
      r_segment     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_wrap;
      if (enable && w_show) begin
        r_bytee   <= w_en;
        r_segment <= w_seg;
      end else begin
        r_bytee   <= '0;
        r_segment <= '0;
      end
    end
  end

  assign byte_status = r_slot;
  assign bytee       = r_bytee;
  assign segment     = r_segment;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: each task queues the per-cycle
// outputs it expects for a frame, a monitor pops and compares once per cycle.
module tb_display_scan_ctrl;

  localparam int PS = 4;
  localparam int BF = 2;
  localparam int FRAME = 8 * PS;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] data_show = '0;
  logic [1:0]  blink_mask = '0;
  logic [2:0]  byte_status;
  logic [3:0]  bytee;
  logic [6:0]  segment;
  logic        frame_start;

  typedef struct packed {
    logic [2:0] slot;
    logic [3:0] en;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  exp_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    mon_idx = 0;
  int    fr = 0;
  string cur = "";

  display_scan_ctrl #(.PRESCALE(PS), .BLINK_FRAMES(BF)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .data_show   (data_show),
    .blink_mask  (blink_mask),
    .byte_status (byte_status),
    .bytee       (bytee),
    .segment     (segment),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  // Monitor: outputs only move on posedge/reset, so sample 1 ns after negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({byte_status, bytee, segment, frame_start} !== e) begin
          bad++;
          $display("FAIL %s idx=%0d got slot=%0d bytee=%b seg=%h fs=%b, want slot=%0d bytee=%b seg=%h fs=%b",
                   cur, mon_idx, byte_status, bytee, segment, frame_start,
                   e.slot, e.en, e.seg, e.fs);
        end
        mon_idx++;
      end
    end
  end

  // Queue n cycles of a frame; an optional 10-cycle enable pause follows index pause_at.
  task automatic push_frame(input int lo, input int hi, input logic [1:0] mask,
                            input bit fs0, input int pause_at, input int n);
    bit vis;
    vis = ((fr / BF) % 2) == 0;
    mon_idx = 0;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   s;
      int   d;
      bit   blank;
      s = k / PS;
      d = 0;
      blank = 1'b0;
      e.slot = 3'(s);
      e.fs = (k == 0) ? fs0 : 1'b0;
      e.en = 4'b0000;
      e.seg = 7'h00;
      case (s)
        1: begin e.en = 4'b0001; d = lo % 10; blank = !vis && mask[0]; end
        3: begin e.en = 4'b0010; d = lo / 10; blank = !vis && mask[0]; end
        5: begin e.en = 4'b0100; d = hi % 10; blank = !vis && mask[1]; end
        7: begin e.en = 4'b1000; d = hi / 10; blank = !vis && mask[1]; end
        default: ;
      endcase
      if (s % 2 == 1) begin
        if (blank) e.en = 4'b0000;
        else e.seg = seg_tbl[d];
      end
      sb.push_back(e);
      if (k == pause_at) begin
        for (int p = 0; p < 10; p++) sb.push_back('{slot: 3'(s), en: 4'b0, seg: 7'h00, fs: 1'b0});
      end
    end
  endtask

  task automatic wait_idx(input int k);
    int n;
    n = 0;
    while (mon_idx < k + 1 && n < 100) begin
      @(negedge clock);
      #2;
      n++;
    end
    total++;
    if (mon_idx < k + 1) begin
      bad++;
      $display("FAIL %s wait_idx got=%0d want=%0d", cur, mon_idx, k + 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clock);
      #2;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s drain left=%0d want=0", cur, sb.size());
      sb.delete();
    end
    fr++;
  endtask

  task automatic test_reset();
    cur = "reset";
    enable = 1'b1;
    data_show = {6'd23, 6'd45};
    #3 reset = 1'b1;
    #4;
    total++;
    if ({byte_status, bytee, segment, frame_start} !== 15'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {byte_status, bytee, segment, frame_start});
    end
    @(negedge clock);
    reset = 1'b0;
    fr = 0;
    cur = "first_frame";
    push_frame(0, 0, 2'b00, 1'b0, -1, FRAME);
    drain();
  endtask

  task automatic test_digits();
    cur = "digits_23_45";
    push_frame(45, 23, 2'b00, 1'b1, -1, FRAME);
    drain();
  endtask

  task automatic test_no_tear();
    cur = "no_tear";
    push_frame(45, 23, 2'b00, 1'b1, -1, FRAME);
    wait_idx(12);
    data_show = {6'd23, 6'd12};
    drain();
    cur = "after_change";
    push_frame(12, 23, 2'b00, 1'b1, -1, FRAME);
    drain();
  endtask

  task automatic test_max_blink();
    data_show = {6'd60, 6'd63};
    blink_mask = 2'b10;
    for (int f = 0; f < 5; f++) begin
      cur = "max_blink";
      push_frame(63, 60, 2'b10, 1'b1, -1, FRAME);
      drain();
    end
    data_show = {6'd23, 6'd45};
    blink_mask = 2'b00;
  endtask

  task automatic test_enable();
    cur = "enable_pause";
    push_frame(45, 23, 2'b00, 1'b1, 21, FRAME);
    wait_idx(21);
    enable = 1'b0;
    wait_idx(31);
    enable = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    cur = "pre_reset";
    push_frame(45, 23, 2'b00, 1'b1, -1, 30);
    wait_idx(29);
    sb.delete();
    reset = 1'b1;
    #1;
    total++;
    if ({byte_status, bytee, segment, frame_start} !== 15'd0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0", {byte_status, bytee, segment, frame_start});
    end
    fr = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    cur = "post_reset";
    push_frame(0, 0, 2'b00, 1'b0, -1, FRAME);
    drain();
    cur = "back_to_back";
    push_frame(45, 23, 2'b00, 1'b1, -1, FRAME);
    drain();
  endtask

  initial begin
    test_reset();
    test_digits();
    test_no_tear();
    test_max_blink();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
